// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_pkg
//  Description : Shared types, register map, control-field offsets and the
//                hex-to-segment table for the seven-segment scan controller.
//  Revision    : 1.0  initial release
// ============================================================================
package seg7_pkg;

    // Scan sequencer states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        ON    = 2'd2
    } state_e;

    // Register word addresses (address 3 is reserved)
    localparam logic [1:0] ADR_DATA     = 2'd0;
    localparam logic [1:0] ADR_CTRL     = 2'd1;
    localparam logic [1:0] ADR_PRESCALE = 2'd2;

    // CTRL field layout
    localparam int CTRL_MASK_LSB   = 0;
    localparam int CTRL_BRIGHT_LSB = 4;
    localparam int CTRL_EN_BIT     = 8;
    localparam int CTRL_WIDTH      = 9;

    // Active-low cathodes, bit 0 = segA .. bit 6 = segG; entry n is hex digit n
    localparam logic [15:0][6:0] SEG_LUT = {
        7'b0001110,   // F
        7'b0000110,   // E
        7'b0100001,   // d
        7'b1000110,   // C
        7'b0000011,   // b
        7'b0001000,   // A
        7'b0010000,   // 9
        7'b0000000,   // 8
        7'b1111000,   // 7
        7'b0000010,   // 6
        7'b0010010,   // 5
        7'b0011001,   // 4
        7'b0110000,   // 3
        7'b0100100,   // 2
        7'b1111001,   // 1
        7'b1000000    // 0
    };

    // Next enabled digit strictly after idx in ascending order, wrapping.
    // Falls back to idx itself when it is the only enabled digit.
    function automatic logic [1:0] next_digit(input logic [3:0] mask,
                                              input logic [1:0] idx);
        logic [1:0] cand;
        logic [1:0] res;
        res = idx;
        // Walk farthest-first so the nearest enabled candidate wins last
        for (int i = 4; i >= 1; i--) begin
            cand = idx + 2'(i);
            if (mask[cand]) res = cand;
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seg7_decode.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_decode
//  Description : Combinational hex nibble to active-low cathode pattern.
//  Revision    : 1.0  initial release
// ============================================================================
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [6:0] o_seg
);

    // Straight table lookup
    always_comb begin
        o_seg = SEG_LUT[i_nibble];
    end

endmodule
`default_nettype wire

// File: rtl/wb_seg7_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : wb_seg7_scan_ctrl
//  Description : Wishbone slave driving a common-anode multiplexed seven-
//                segment display: digit data, enable mask, PWM brightness and
//                refresh prescaler, with a blank guard tick per digit slot.
//  Revision    : 1.0  initial release
// ============================================================================
module wb_seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int          WORD         = 16,
    parameter int          DISPLAYS     = 4,
    parameter logic [15:0] PRESCALE_RST = 16'd999
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                stb_i,
    input  logic                cyc_i,
    input  logic                we_i,
    input  logic [1:0]          adr_i,
    input  logic [WORD/8-1:0]   sel_i,
    input  logic [WORD-1:0]     dat_i,
    output logic                ack_o,
    output logic [WORD-1:0]     dat_o,
    output logic [DISPLAYS-1:0] dispSel_o,
    output logic [6:0]          disp_o
);

    localparam logic [3:0]            C_MASK_ALL = 4'((1 << DISPLAYS) - 1);
    localparam logic [CTRL_WIDTH-1:0] C_CTRL_RST = {1'b1, 4'd15, C_MASK_ALL};

    // Registered state
    logic                  r_ack_q;
    logic [WORD-1:0]       r_dat_q;
    logic [WORD-1:0]       r_data_q;
    logic [CTRL_WIDTH-1:0] r_ctrl_q;
    logic [WORD-1:0]       r_presc_q;
    logic [WORD-1:0]       r_tick_cnt_q;
    logic [3:0]            r_slot_q;
    logic [1:0]            r_idx_q;
    logic [3:0]            r_nib_q;
    state_e                r_state_q;
    logic [DISPLAYS-1:0]   r_sel_q;
    logic [6:0]            r_seg_q;

    // Next-state values
    logic                  w_ack_d;
    logic [WORD-1:0]       w_dat_d;
    logic [WORD-1:0]       w_data_d;
    logic [CTRL_WIDTH-1:0] w_ctrl_d;
    logic [WORD-1:0]       w_presc_d;
    logic [WORD-1:0]       w_tick_cnt_d;
    logic [3:0]            w_slot_d;
    logic [1:0]            w_idx_d;
    logic [3:0]            w_nib_d;
    state_e                w_state_d;
    logic [DISPLAYS-1:0]   w_sel_d;
    logic [6:0]            w_seg_d;

    // Helpers
    logic                  w_req;
    logic                  w_wr;
    logic                  w_presc_wr;
    logic [WORD-1:0]       w_bmask;
    logic [WORD-1:0]       w_rd;
    logic [3:0]            w_mask;
    logic [3:0]            w_bright;
    logic                  w_run;
    logic                  w_tick;
    logic [3:0]            w_slot_nxt;
    logic [15:0]           w_data_lo;
    logic [6:0]            w_dec;

    // Bus handshake, read mux and byte-wise register writes on the ack cycle
    always_comb begin
        w_req      = stb_i & cyc_i;
        w_ack_d    = w_req & ~r_ack_q;
        w_wr       = r_ack_q & w_req & we_i;
        w_presc_wr = w_wr && (adr_i == ADR_PRESCALE);

        w_bmask = '0;
        for (int b = 0; b < WORD/8; b++) begin
            w_bmask[8*b +: 8] = {8{sel_i[b]}};
        end

        case (adr_i)
            ADR_DATA:     w_rd = r_data_q;
            ADR_CTRL:     w_rd = {{(WORD-CTRL_WIDTH){1'b0}}, r_ctrl_q};
            ADR_PRESCALE: w_rd = r_presc_q;
            default:      w_rd = '0;
        endcase
        w_dat_d = w_ack_d ? w_rd : r_dat_q;

        w_data_d  = r_data_q;
        w_ctrl_d  = r_ctrl_q;
        w_presc_d = r_presc_q;
        if (w_wr) begin
            case (adr_i)
                ADR_DATA:     w_data_d  = (r_data_q & ~w_bmask) | (dat_i & w_bmask);
                ADR_CTRL:     w_ctrl_d  = (r_ctrl_q & ~w_bmask[CTRL_WIDTH-1:0])
                                        | (dat_i[CTRL_WIDTH-1:0] & w_bmask[CTRL_WIDTH-1:0]);
                ADR_PRESCALE: w_presc_d = (r_presc_q & ~w_bmask) | (dat_i & w_bmask);
                default:      ;
            endcase
        end
    end

    // Scan sequencer: prescaler tick, slot counter, digit advance and PWM
    always_comb begin
        // Use the value being committed so EN/MASK clears act on the very next edge
        w_mask     = w_ctrl_d[CTRL_MASK_LSB +: 4] & C_MASK_ALL;
        w_bright   = w_ctrl_d[CTRL_BRIGHT_LSB +: 4];
        w_run      = w_ctrl_d[CTRL_EN_BIT] && (w_mask != 4'd0);
        w_tick     = (r_tick_cnt_q >= r_presc_q);
        w_slot_nxt = r_slot_q + 4'd1;
        w_data_lo  = r_data_q[15:0];

        w_state_d    = r_state_q;
        w_slot_d     = r_slot_q;
        w_idx_d      = r_idx_q;
        w_nib_d      = r_nib_q;
        w_tick_cnt_d = r_tick_cnt_q;

        if (!w_run) begin
            // Counters freeze while parked
            w_state_d = IDLE;
        end else if (r_state_q == IDLE) begin
            // Searching from digit 3 upward lands on the lowest enabled digit
            w_state_d    = BLANK;
            w_slot_d     = 4'd0;
            w_tick_cnt_d = '0;
            w_idx_d      = next_digit(w_mask, 2'd3);
            w_nib_d      = w_data_lo[{w_idx_d, 2'b00} +: 4];
        end else begin
            w_tick_cnt_d = w_tick ? '0 : r_tick_cnt_q + WORD'(1);
            if (w_tick) begin
                if (r_slot_q == 4'd15) begin
                    // Slot boundary: next digit, nibble latched once per slot
                    w_slot_d  = 4'd0;
                    w_state_d = BLANK;
                    w_idx_d   = next_digit(w_mask, r_idx_q);
                    w_nib_d   = w_data_lo[{w_idx_d, 2'b00} +: 4];
                end else begin
                    w_slot_d  = w_slot_nxt;
                    w_state_d = (w_slot_nxt <= w_bright) ? ON : BLANK;
                end
            end
        end

        if (w_presc_wr) begin
            w_tick_cnt_d = '0;
        end

        w_seg_d = (w_state_d == ON) ? w_dec : 7'h7F;
        for (int i = 0; i < DISPLAYS; i++) begin
            w_sel_d[i] = ~((w_state_d == ON) && (w_idx_d == 2'(i)));
        end
    end

    seg7_decode u_decode (
        .i_nibble (w_nib_d),
        .o_seg    (w_dec)
    );

    // All state registers with synchronous active-low reset
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_ack_q      <= 1'b0;
            r_dat_q      <= '0;
            r_data_q     <= '0;
            r_ctrl_q     <= C_CTRL_RST;
            r_presc_q    <= WORD'(PRESCALE_RST);
            r_tick_cnt_q <= '0;
            r_slot_q     <= 4'd0;
            r_idx_q      <= 2'd0;
            r_nib_q      <= 4'd0;
            r_state_q    <= IDLE;
            r_sel_q      <= '1;
            r_seg_q      <= 7'h7F;
        end else begin
            r_ack_q      <= w_ack_d;
            r_dat_q      <= w_dat_d;
            r_data_q     <= w_data_d;
            r_ctrl_q     <= w_ctrl_d;
            r_presc_q    <= w_presc_d;
            r_tick_cnt_q <= w_tick_cnt_d;
            r_slot_q     <= w_slot_d;
            r_idx_q      <= w_idx_d;
            r_nib_q      <= w_nib_d;
            r_state_q    <= w_state_d;
            r_sel_q      <= w_sel_d;
            r_seg_q      <= w_seg_d;
        end
    end

    assign ack_o     = r_ack_q;
    assign dat_o     = r_dat_q;
    assign dispSel_o = r_sel_q;
    assign disp_o    = r_seg_q;

endmodule
`default_nettype wire

// File: tb/tb_wb_seg7_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wb_seg7_scan_ctrl
//  Description : Directed self-checking bench for wb_seg7_scan_ctrl.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_wb_seg7_scan_ctrl;

    localparam logic [1:0] A_DATA = 2'd0;
    localparam logic [1:0] A_CTRL = 2'd1;
    localparam logic [1:0] A_PRE  = 2'd2;
    localparam int         LOGN   = 4096;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic        stb, cyc, we;
    logic [1:0]  adr;
    logic [1:0]  sel;
    logic [15:0] dat_w;
    logic        ack_o;
    logic [15:0] dat_o;
    logic [3:0]  dispSel_o;
    logic [6:0]  disp_o;

    int errors = 0;
    int checks = 0;

    logic [3:0] sel_log [0:LOGN-1];
    logic [6:0] seg_log [0:LOGN-1];
    int         ncyc = 0;

    wb_seg7_scan_ctrl #(.WORD(16), .DISPLAYS(4), .PRESCALE_RST(16'd999)) dut (
        .clk_i     (clk),
        .rst_ni    (rst_ni),
        .stb_i     (stb),
        .cyc_i     (cyc),
        .we_i      (we),
        .adr_i     (adr),
        .sel_i     (sel),
        .dat_i     (dat_w),
        .ack_o     (ack_o),
        .dat_o     (dat_o),
        .dispSel_o (dispSel_o),
        .disp_o    (disp_o)
    );

    always #5 clk = ~clk;

    // Record display outputs once per cycle, mid-cycle
    always @(negedge clk) begin
        if (ncyc < LOGN) begin
            sel_log[ncyc] = dispSel_o;
            seg_log[ncyc] = disp_o;
        end
        ncyc++;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] seg_of(input logic [3:0] n);
        case (n)
            4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
            4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
            4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
            4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
        endcase
    endfunction

    task automatic bus_write(input logic [1:0] a, input logic [15:0] d,
                             input logic [1:0] s, input bit hs);
        int n;
        @(posedge clk); #1;
        stb = 1'b1; cyc = 1'b1; we = 1'b1; adr = a; dat_w = d; sel = s;
        if (hs) chk("ack_before", {31'd0, ack_o}, 32'd0);
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!ack_o && n < 8);
        if (!ack_o) chk("wr_ack_timeout", 32'd0, 32'd1);
        if (hs) chk("ack_latency", n, 32'd1);
        @(posedge clk); #1;
        if (hs) chk("ack_width", {31'd0, ack_o}, 32'd0);
        stb = 1'b0; cyc = 1'b0; we = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [15:0] d);
        int n;
        @(posedge clk); #1;
        stb = 1'b1; cyc = 1'b1; we = 1'b0; adr = a; sel = 2'b11;
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!ack_o && n < 8);
        if (!ack_o) chk("rd_ack_timeout", 32'd0, 32'd1);
        d = dat_o;
        @(posedge clk); #1;
        stb = 1'b0; cyc = 1'b0;
    endtask

    // Park with EN=0, then re-enable: scan restarts at slot 0 of the lowest digit
    task automatic restart(input logic [15:0] ctrl, output int n0);
        bus_write(A_CTRL, ctrl & 16'hFEFF, 2'b11, 1'b0);
        chk("en_off_sel", {28'd0, dispSel_o}, 32'hF);
        bus_write(A_CTRL, ctrl, 2'b11, 1'b0);
        n0 = ncyc;
    endtask

    task automatic wait_to(input int target);
        while (ncyc < target) begin @(posedge clk); #1; end
    endtask

    // Compare logged outputs against the expected scan pattern from sample st
    task automatic check_scan(input string tag, input int st, input int len,
                              input int p, input int b, input logic [3:0] m,
                              input logic [15:0] d_old, input logic [15:0] d_new,
                              input int chg);
        int dl[4];
        int nd, mism, t, k, n, dig, ss;
        logic [15:0] d;
        logic [3:0]  es;
        logic [6:0]  eg;
        nd = 0;
        for (int i = 0; i < 4; i++) if (m[i]) begin dl[nd] = i; nd++; end
        mism = 0;
        for (int s = 0; s < len; s++) begin
            t   = s / (p + 1);
            k   = t / 16;
            n   = t % 16;
            dig = dl[k % nd];
            ss  = k * 16 * (p + 1);
            d   = (ss > chg) ? d_new : d_old;
            if (n >= 1 && n <= b) begin
                es = ~(4'b0001 << dig);
                eg = seg_of(d[4*dig +: 4]);
            end else begin
                es = 4'hF;
                eg = 7'h7F;
            end
            if (sel_log[st+s] !== es || seg_log[st+s] !== eg) mism++;
        end
        chk(tag, mism, 32'd0);
    endtask

    initial begin
        logic [15:0] rd;
        int n0, nw, cnt, n;

        stb = 1'b0; cyc = 1'b0; we = 1'b0; adr = 2'd0; sel = 2'd0; dat_w = 16'd0;
        rst_ni = 1'b0;

        // Reset then idle
        repeat (2) @(posedge clk);
        #1;
        chk("rst_sel",  {28'd0, dispSel_o}, 32'hF);
        chk("rst_seg",  {25'd0, disp_o},    32'h7F);
        chk("rst_ack",  {31'd0, ack_o},     32'd0);
        chk("rst_dato", {16'd0, dat_o},     32'd0);
        rst_ni = 1'b1;
        bus_read(A_CTRL, rd);  chk("rst_ctrl", {16'd0, rd}, 32'h01FF);
        bus_read(A_PRE, rd);   chk("rst_pre",  {16'd0, rd}, 32'd999);
        bus_read(2'd3, rd);    chk("rsvd_rd",  {16'd0, rd}, 32'd0);

        // Full-brightness scan
        bus_write(A_PRE, 16'd0, 2'b11, 1'b0);
        bus_write(A_DATA, 16'h1234, 2'b11, 1'b0);
        restart(16'h01FF, n0);
        wait_to(n0 + 72);
        check_scan("full_scan", n0, 70, 0, 15, 4'hF, 16'h1234, 16'h1234, 1 << 30);
        chk("full_guard", {28'd0, sel_log[n0]},   32'hF);
        chk("full_d0_seg", {25'd0, seg_log[n0+1]}, 32'h19);
        cnt = 0;
        for (int i = 0; i < 16; i++) if (sel_log[n0+i] == 4'b1110) cnt++;
        chk("full_d0_on", cnt, 32'd15);
        chk("full_period", {28'd0, sel_log[n0+65]}, 32'hE);

        // Dimming: BRIGHT=3, PRESCALE=1
        bus_write(A_PRE, 16'd1, 2'b11, 1'b0);
        restart(16'h013F, n0);
        wait_to(n0 + 134);
        check_scan("dim_scan", n0, 132, 1, 3, 4'hF, 16'h1234, 16'h1234, 1 << 30);
        cnt = 0;
        for (int i = 0; i < 32; i++) if (sel_log[n0+i] != 4'hF) cnt++;
        chk("dim_on_clks", cnt, 32'd6);

        // Mask skip: digits 0 and 2 only, then MASK=0
        bus_write(A_PRE, 16'd0, 2'b11, 1'b0);
        restart(16'h01F5, n0);
        wait_to(n0 + 82);
        check_scan("mask_scan", n0, 80, 0, 15, 4'b0101, 16'h1234, 16'h1234, 1 << 30);
        cnt = 0;
        for (int i = 0; i < 80; i++)
            if (sel_log[n0+i] == 4'b1101 || sel_log[n0+i] == 4'b0111) cnt++;
        chk("mask_skipped", cnt, 32'd0);
        bus_write(A_CTRL, 16'h01F0, 2'b11, 1'b0);
        chk("mask0_sel", {28'd0, dispSel_o}, 32'hF);
        chk("mask0_seg", {25'd0, disp_o},    32'h7F);

        // Byte write during digit 2's slot, with handshake checks
        restart(16'h01FF, n0);
        wait_to(n0 + 34);
        bus_write(A_DATA, 16'hAB00, 2'b10, 1'b1);
        nw = ncyc;
        wait_to(n0 + 138);
        check_scan("bytewr_scan", n0, 136, 0, 15, 4'hF, 16'h1234, 16'hAB34, nw - n0);
        chk("bytewr_d2_hold", {25'd0, seg_log[n0+40]},  32'h24);
        chk("bytewr_d3_new",  {25'd0, seg_log[n0+56]},  32'h08);
        chk("bytewr_d2_new",  {25'd0, seg_log[n0+104]}, 32'h03);
        bus_read(A_DATA, rd);
        chk("bytewr_data", {16'd0, rd}, 32'hAB34);

        // Reset during an ON slot
        restart(16'h01FF, n0);
        wait_to(n0 + 5);
        chk("pre_rst_on", {28'd0, dispSel_o}, 32'hE);
        rst_ni = 1'b0;
        @(posedge clk); #1;
        chk("midrst_sel", {28'd0, dispSel_o}, 32'hF);
        chk("midrst_seg", {25'd0, disp_o},    32'h7F);
        @(posedge clk); #1;
        rst_ni = 1'b1;
        n = 0;
        do begin @(posedge clk); #1; n++; end while (dispSel_o == 4'hF && n < 1200);
        chk("resume_clks", n, 32'd1001);
        chk("resume_sel", {28'd0, dispSel_o}, 32'hE);
        chk("resume_seg", {25'd0, disp_o},    32'h40);
        bus_read(A_CTRL, rd);  chk("midrst_ctrl", {16'd0, rd}, 32'h01FF);
        bus_read(A_PRE, rd);   chk("midrst_pre",  {16'd0, rd}, 32'd999);
        bus_read(A_DATA, rd);  chk("midrst_data", {16'd0, rd}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
